mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serialising memory controller between the CPU core's instruction-fetch and data ports and the 8-bit system memory bus (RAM, plus HCI I/O at addresses whose bits [17:16] are 2'b11). It arbitrates the two requesters, splits each word, halfword or byte access into little-endian byte transfers with one-cycle read latency, and returns assembled data with a done pulse. It honours the bus-pause input driven while the host debug interface owns the bus.

## Interface
- ADDR_W, 32: width of request and bus addresses
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- rdy  in  1  bus grant; 0 = bus owned by debug host, controller pauses
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address (word, little-endian)
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched word
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data, low bytes used
- d_done  out  1  one-cycle pulse; d_rdata valid for loads
- d_rdata  out  32  load data, zero-extended (core sign-extends)
- mem_din  in  8  read byte from bus
- mem_dout  out  8  write byte to bus
- mem_a  out  ADDR_W  bus address
- mem_wr  out  1  1 = write strobe

## Operation
- Reset (rst=0 at edge): state IDLE; mem_a=0, mem_wr=0, mem_dout=0, if_done=0, d_done=0, if_data=0, d_rdata=0, counters 0, fetch buffer invalid.
- States: IDLE, READ, WRITE, DONE.
- IDLE: d_req wins over if_req when both high; latch addr, size n (1/2/4), we, wdata; go READ (load/fetch) or WRITE (store).
- READ: issue index i drives mem_a=addr+i, advances each cycle until n issued; capture index j stores mem_din into byte j of the data register the cycle after byte j was issued; after byte n-1 captured -> DONE.
- WRITE: mem_a=addr+i, mem_dout=wdata[8i+7:8i], mem_wr=1 for i=0..n-1, one byte per cycle; after last -> DONE.
- DONE: pulse matching done for one cycle, output data held stable until next completion; -> IDLE. Requests seen in the DONE cycle are ignored.
- Address arithmetic mod 2^ADDR_W; no alignment check, misaligned accesses just walk consecutive bytes.
- Loads to I/O region proceed identically; core guarantees byte size there.
- rdy=0: no issue, no capture, mem_wr forced 0, state held; on the first rdy=1 cycle the issue index rolls back to the capture index (in-flight byte reissued, since bus data during the pause belongs to the host).
- rst=0 mid-operation aborts immediately; no done pulse; partially written bytes remain written.

## Timing
- T = cycle request sampled in IDLE. Byte k issued at T+1+k (no pause).
- Read of n bytes: last capture at end of T+n+1; done high in T+n+2 (byte 3 cycles, half 4, word 6 after T).
- Store of n bytes: mem_wr high T+1..T+n; done high T+n+1.
- Earliest next acceptance: cycle after the done pulse.
- Each rdy=0 cycle adds at least one cycle; a pause during READ adds one extra cycle for the reissue.

## Configuration
- MEMCTRL_FETCH_BUF_EN defined: one-word fetch buffer (tag = if_addr[ADDR_W-1:2], valid bit). Fetch hit in IDLE with no d_req -> if_done in T+1, no bus traffic. Buffer filled by every completed aligned word fetch; invalidated by any store whose byte range overlaps the tagged word, and by reset.
- Undefined: every fetch goes to the bus; if_done at T+6.

## Test plan
- Word fetch, RAM[0x100..0x103]=13,05,00,00 -> if_data=0x00000513, if_done at T+6, mem_a 0x100..0x103 in T+1..T+4.
- Simultaneous if_req (0x200) and d_req load byte 0x30000 (host returns 0x41) -> d_done first, d_rdata=0x00000041 at T+3; fetch accepted after.
- Store halfword 0xBEEF to 0x1001 -> mem_wr in T+1 (0x1001, EF), T+2 (0x1002, BE); d_done T+3; reload returns 0x0000BEEF.
- Word load with rdy=0 for 3 cycles after byte 1 issued -> correct word, no mem_wr, done at T+6+4.
- rst=0 in T+2 of word store -> all outputs reset values next cycle, no d_done, IDLE.
- With MEMCTRL_FETCH_BUF_EN: fetch 0x100 twice -> second done at T+1 with no bus traffic; store byte to 0x102, refetch -> bus access, updated word.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: arbitrates fetch/data requests onto an 8-bit bus.
// Latency: byte k issued at T+1+k; read done at T+n+2, write done at T+n+1 (fetch-buffer hit: T+1).
// Backpressure: rdy=0 freezes issue/capture and blocks writes; READ reissues the in-flight byte on resume.
// Optional one-word fetch buffer enabled by defining MEMCTRL_FETCH_BUF_EN.
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_done,
   output logic [31:0]       d_rdata,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        n_q, n_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              is_d_q, is_d_d;
   logic [2:0]        issue_q, issue_d;
   logic [2:0]        cap_q, cap_d;
   logic              paused_q, paused_d;
   logic [31:0]       data_q, data_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic [2:0]        req_n;
   logic              fb_hit;
   logic [31:0]       fb_dat;

   assign req_n   = (d_size == 2'b00) ? 3'd1 : (d_size == 2'b01) ? 3'd2 : 3'd4;
   assign if_data = if_data_q;
   assign d_rdata = d_rdata_q;

`ifdef MEMCTRL_FETCH_BUF_EN
   logic              fb_vld_q, fb_vld_d;
   logic [ADDR_W-3:0] fb_tag_q, fb_tag_d;
   logic [31:0]       fb_dat_q, fb_dat_d;
   logic              st_ovl;

   // Only aligned fetches can hit: the buffer always holds an aligned word.
   assign fb_hit = fb_vld_q && (if_addr[1:0] == 2'b00) && (if_addr[ADDR_W-1:2] == fb_tag_q);
   assign fb_dat = fb_dat_q;

   // Does the incoming store touch any byte of the buffered word?
   always_comb begin
      logic [ADDR_W-1:0] a_k;
      st_ovl = 1'b0;
      a_k    = '0;
      for (int k = 0; k < 4; k++) begin
         a_k = d_addr + ADDR_W'(k);
         if ((3'(k) < req_n) && (a_k[ADDR_W-1:2] == fb_tag_q))
            st_ovl = 1'b1;
      end
   end

   // Fill on every completed aligned fetch, drop on an overlapping store.
   always_comb begin
      fb_vld_d = fb_vld_q;
      fb_tag_d = fb_tag_q;
      fb_dat_d = fb_dat_q;
      if (state_q == S_DONE && !is_d_q && addr_q[1:0] == 2'b00) begin
         fb_vld_d = 1'b1;
         fb_tag_d = addr_q[ADDR_W-1:2];
         fb_dat_d = if_data_q;
      end
      if (state_q == S_IDLE && rdy && d_req && d_we && st_ovl)
         fb_vld_d = 1'b0;
   end

   // Fetch buffer registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fb_vld_q <= 1'b0;
         fb_tag_q <= '0;
         fb_dat_q <= '0;
      end else begin
         fb_vld_q <= fb_vld_d;
         fb_tag_q <= fb_tag_d;
         fb_dat_q <= fb_dat_d;
      end
   end
`else
   assign fb_hit = 1'b0;
   assign fb_dat = '0;
`endif

   // Next-state, bus drive and byte assembly.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      n_d       = n_q;
      wdata_d   = wdata_q;
      is_d_d    = is_d_q;
      issue_d   = issue_q;
      cap_d     = cap_q;
      paused_d  = paused_q;
      data_d    = data_q;
      if_data_d = if_data_q;
      d_rdata_d = d_rdata_q;
      mem_a     = '0;
      mem_dout  = '0;
      mem_wr    = 1'b0;
      if_done   = 1'b0;
      d_done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rdy) begin
               if (d_req) begin
                  addr_d   = d_addr;
                  n_d      = req_n;
                  wdata_d  = d_wdata;
                  is_d_d   = 1'b1;
                  issue_d  = '0;
                  cap_d    = '0;
                  paused_d = 1'b0;
                  data_d   = '0;
                  state_d  = d_we ? S_WRITE : S_READ;
               end else if (if_req && fb_hit) begin
                  addr_d    = if_addr;
                  is_d_d    = 1'b0;
                  if_data_d = fb_dat;
                  state_d   = S_DONE;
               end else if (if_req) begin
                  addr_d   = if_addr;
                  n_d      = 3'd4;
                  is_d_d   = 1'b0;
                  issue_d  = '0;
                  cap_d    = '0;
                  paused_d = 1'b0;
                  data_d   = '0;
                  state_d  = S_READ;
               end
            end
         end
         S_READ: begin
            if (!rdy) begin
               paused_d = 1'b1;
            end else if (paused_q) begin
               // Bus data seen during the pause was the host's: reissue the in-flight byte.
               mem_a    = addr_q + ADDR_W'(cap_q);
               issue_d  = cap_q + 3'd1;
               paused_d = 1'b0;
            end else begin
               if (issue_q < n_q) begin
                  mem_a   = addr_q + ADDR_W'(issue_q);
                  issue_d = issue_q + 3'd1;
               end
               if (cap_q < issue_q) begin
                  data_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
                  cap_d = cap_q + 3'd1;
                  if (cap_q == n_q - 3'd1) begin
                     state_d = S_DONE;
                     if (is_d_q) d_rdata_d = data_d;
                     else        if_data_d = data_d;
                  end
               end
            end
         end
         S_WRITE: begin
            if (rdy) begin
               mem_a    = addr_q + ADDR_W'(issue_q);
               mem_dout = wdata_q[{issue_q[1:0], 3'b000} +: 8];
               mem_wr   = 1'b1;
               issue_d  = issue_q + 3'd1;
               if (issue_q == n_q - 3'd1) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if_done = !is_d_q;
            d_done  = is_d_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         n_q       <= '0;
         wdata_q   <= '0;
         is_d_q    <= 1'b0;
         issue_q   <= '0;
         cap_q     <= '0;
         paused_q  <= 1'b0;
         data_q    <= '0;
         if_data_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         n_q       <= n_d;
         wdata_q   <= wdata_d;
         is_d_q    <= is_d_d;
         issue_q   <= issue_d;
         cap_q     <= cap_d;
         paused_q  <= paused_d;
         data_q    <= data_d;
         if_data_q <= if_data_d;
         d_rdata_q <= d_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous memory model.
// Cycle numbering: T is the cycle whose closing edge samples the request; t=1 is T+1.
// Host-owned bus cycles (rdy=0) return 8'hEE to expose any wrong capture.
module tb_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst, rdy, if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [1:0]  d_size;
   logic        if_done, d_done, mem_wr;
   logic [31:0] if_data, d_rdata, mem_a;
   logic [7:0]  mem_din, mem_dout, rd_q;

   logic [7:0]  mem [logic [31:0]];
   logic [31:0] tr_a  [0:40];
   logic        tr_wr [0:40];
   logic [7:0]  tr_do [0:40];
   int n_checks = 0;
   int n_fail   = 0;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   // Synchronous byte memory; one-cycle read latency.
   always @(posedge clk) begin
      if (mem_wr) mem[mem_a] = mem_dout;
      rd_q <= rdy ? rd(mem_a) : 8'hEE;
   end
   assign mem_din = rd_q;

   // Runs one request; rdy is low for cycles T+p_from .. T+p_from+p_len-1.
   task automatic do_access(input logic is_d, input logic we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int p_from, input int p_len,
                            output int done_t, output logic [31:0] data);
      for (int i = 0; i <= 40; i++) begin
         tr_a[i] = '0; tr_wr[i] = 1'b0; tr_do[i] = '0;
      end
      done_t = -1;
      data   = '0;
      @(negedge clk);
      rdy = 1'b1;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      for (int t = 1; t <= 40 && done_t < 0; t++) begin
         @(negedge clk);
         rdy = !(t >= p_from && t < p_from + p_len);
         #1;
         tr_a[t] = mem_a; tr_wr[t] = mem_wr; tr_do[t] = mem_dout;
         if (is_d ? d_done : if_done) begin
            done_t = t;
            data   = is_d ? d_rdata : if_data;
         end
      end
      d_req  = 1'b0;
      if_req = 1'b0;
      rdy    = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; rdy = 1'b1; if_req = 0; d_req = 0; d_we = 0; d_size = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
      n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
      n_checks++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
      n_checks++; if ({if_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", {if_done, d_done}); end
      n_checks++; if (if_data !== 32'h0) begin n_fail++; $display("FAIL reset_if_data: got %h want 0", if_data); end
      n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
      rst = 1'b1;
   endtask

   task automatic test_word_fetch();
      int dt; logic [31:0] dv;
      do_access(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 99, 0, dt, dv);
      n_checks++; if (dt !== 6) begin n_fail++; $display("FAIL fetch_done_cycle: got %0d want 6", dt); end
      n_checks++; if (dv !== 32'h00000513) begin n_fail++; $display("FAIL fetch_data: got %h want 00000513", dv); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (tr_a[k+1] !== 32'h100 + k || tr_wr[k+1] !== 1'b0) begin
            n_fail++; $display("FAIL fetch_addr_t%0d: got %h wr=%b want %h wr=0", k+1, tr_a[k+1], tr_wr[k+1], 32'h100 + k);
         end
      end
   endtask

   task automatic test_arbitration();
      int dt = -1; int it = -1; logic [31:0] dd = 0; logic [31:0] idat = 0; logic [31:0] a1 = 0;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h200;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h30000;
      for (int t = 1; t <= 30 && (dt < 0 || it < 0); t++) begin
         @(negedge clk); #1;
         if (t == 1) a1 = mem_a;
         if (d_done && dt < 0) begin dt = t; dd = d_rdata; d_req = 1'b0; end
         if (if_done && it < 0) begin it = t; idat = if_data; if_req = 1'b0; end
      end
      d_req = 1'b0; if_req = 1'b0;
      n_checks++; if (a1 !== 32'h30000) begin n_fail++; $display("FAIL arb_first_addr: got %h want 00030000", a1); end
      n_checks++; if (dt !== 3) begin n_fail++; $display("FAIL arb_d_done_cycle: got %0d want 3", dt); end
      n_checks++; if (dd !== 32'h00000041) begin n_fail++; $display("FAIL arb_d_rdata: got %h want 00000041", dd); end
      n_checks++; if (it !== 10) begin n_fail++; $display("FAIL arb_if_done_cycle: got %0d want 10", it); end
      n_checks++; if (idat !== 32'h12345678) begin n_fail++; $display("FAIL arb_if_data: got %h want 12345678", idat); end
   endtask

   task automatic test_store_half();
      int dt; logic [31:0] dv;
      do_access(1'b1, 1'b1, 2'b01, 32'h1001, 32'h0000BEEF, 99, 0, dt, dv);
      n_checks++; if (dt !== 3) begin n_fail++; $display("FAIL sth_done_cycle: got %0d want 3", dt); end
      n_checks++;
      if (tr_wr[1] !== 1'b1 || tr_a[1] !== 32'h1001 || tr_do[1] !== 8'hEF) begin
         n_fail++; $display("FAIL sth_byte0: got wr=%b a=%h d=%h want wr=1 a=00001001 d=ef", tr_wr[1], tr_a[1], tr_do[1]);
      end
      n_checks++;
      if (tr_wr[2] !== 1'b1 || tr_a[2] !== 32'h1002 || tr_do[2] !== 8'hBE) begin
         n_fail++; $display("FAIL sth_byte1: got wr=%b a=%h d=%h want wr=1 a=00001002 d=be", tr_wr[2], tr_a[2], tr_do[2]);
      end
      n_checks++; if (tr_wr[3] !== 1'b0) begin n_fail++; $display("FAIL sth_wr_after: got %b want 0", tr_wr[3]); end
      do_access(1'b1, 1'b0, 2'b01, 32'h1001, 32'h0, 99, 0, dt, dv);
      n_checks++; if (dt !== 4) begin n_fail++; $display("FAIL ldh_done_cycle: got %0d want 4", dt); end
      n_checks++; if (dv !== 32'h0000BEEF) begin n_fail++; $display("FAIL ldh_data: got %h want 0000beef", dv); end
   endtask

   task automatic test_pause();
      int dt; logic [31:0] dv; int wrs = 0;
      do_access(1'b1, 1'b0, 2'b10, 32'h300, 32'h0, 3, 3, dt, dv);
      for (int t = 1; t <= 40; t++) wrs += int'(tr_wr[t]);
      n_checks++; if (dt !== 10) begin n_fail++; $display("FAIL pause_done_cycle: got %0d want 10", dt); end
      n_checks++; if (dv !== 32'hD4C3B2A1) begin n_fail++; $display("FAIL pause_data: got %h want d4c3b2a1", dv); end
      n_checks++; if (wrs !== 0) begin n_fail++; $display("FAIL pause_no_write: got %0d strobes want 0", wrs); end
   endtask

   task automatic test_fetch_buf();
      int dt; logic [31:0] dv; int exp_t;
`ifdef MEMCTRL_FETCH_BUF_EN
      exp_t = 1;
`else
      exp_t = 6;
`endif
      do_access(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 99, 0, dt, dv);
      n_checks++; if (dt !== 6) begin n_fail++; $display("FAIL fb_first_cycle: got %0d want 6", dt); end
      do_access(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 99, 0, dt, dv);
      n_checks++; if (dt !== exp_t) begin n_fail++; $display("FAIL fb_second_cycle: got %0d want %0d", dt, exp_t); end
      n_checks++; if (dv !== 32'h00000513) begin n_fail++; $display("FAIL fb_second_data: got %h want 00000513", dv); end
      do_access(1'b1, 1'b1, 2'b00, 32'h102, 32'h0000005A, 99, 0, dt, dv);
      n_checks++; if (dt !== 2) begin n_fail++; $display("FAIL fb_store_cycle: got %0d want 2", dt); end
      do_access(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 99, 0, dt, dv);
      n_checks++; if (dt !== 6) begin n_fail++; $display("FAIL fb_refetch_cycle: got %0d want 6", dt); end
      n_checks++; if (dv !== 32'h005A0513) begin n_fail++; $display("FAIL fb_refetch_data: got %h want 005a0513", dv); end
   endtask

   task automatic test_abort_reset();
      int dn = 0; int wn = 0; int dt; logic [31:0] dv;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h2000; d_wdata = 32'h11223344;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; d_req = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
         n_fail++; $display("FAIL abort_bus: got a=%h wr=%b d=%h want all 0", mem_a, mem_wr, mem_dout);
      end
      n_checks++;
      if (if_data !== 32'h0 || d_rdata !== 32'h0 || d_done !== 1'b0) begin
         n_fail++; $display("FAIL abort_outputs: got if=%h d=%h done=%b want 0", if_data, d_rdata, d_done);
      end
      rst = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk); #1;
         dn += int'(d_done); wn += int'(mem_wr);
      end
      n_checks++; if (dn !== 0 || wn !== 0) begin n_fail++; $display("FAIL abort_idle: got done=%0d wr=%0d want 0", dn, wn); end
      n_checks++;
      if (rd(32'h2000) !== 8'h44 || rd(32'h2001) !== 8'h33 || rd(32'h2002) !== 8'h00) begin
         n_fail++; $display("FAIL abort_partial: got %h %h %h want 44 33 00", rd(32'h2000), rd(32'h2001), rd(32'h2002));
      end
      do_access(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 99, 0, dt, dv);
      n_checks++; if (dt !== 6) begin n_fail++; $display("FAIL abort_refetch_cycle: got %0d want 6", dt); end
   endtask

   initial begin
      mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
      mem[32'h200] = 8'h78; mem[32'h201] = 8'h56; mem[32'h202] = 8'h34; mem[32'h203] = 8'h12;
      mem[32'h300] = 8'hA1; mem[32'h301] = 8'hB2; mem[32'h302] = 8'hC3; mem[32'h303] = 8'hD4;
      mem[32'h30000] = 8'h41;
      test_reset();
      test_word_fetch();
      test_arbitration();
      test_store_half();
      test_pause();
      test_fetch_buf();
      test_abort_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
